ahblite_bram_if: RTL and testbench

AHBLITE_BRAM_IF -- requirements
Module: ahblite_bram_if

---
 rtl/ahblite_bram_if_pkg.sv | 24 ++
 rtl/ahblite_bram_strb.sv | 30 +++
 rtl/ahblite_bram_if.sv | 115 +++++++++++
 tb/tb_ahblite_bram_if.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_bram_if_pkg.sv
// rtl/ahblite_bram_if_pkg.sv - shared encodings, FSM states and defaults for the AHB-Lite BRAM bridge
package ahblite_bram_if_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 14;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RDATA,
        ST_HAZARD,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahblite_bram_strb.sv
// rtl/ahblite_bram_strb.sv - byte strobe generation and size/alignment legality check
// Ports: addr_lo_i = HADDR[1:0], size_i = HSIZE, strb_o = byte lane enables,
//        illegal_o = unsupported size or misaligned transfer.
module ahblite_bram_strb
    import ahblite_bram_if_pkg::*;
(
    input  logic [1:0] addr_lo_i,
    input  logic [2:0] size_i,
    output logic [3:0] strb_o,
    output logic       illegal_o
);

    always_comb begin
        strb_o    = 4'b0000;
        illegal_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                strb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                illegal_o = addr_lo_i[0];
            end
            HSIZE_WORD: begin
                strb_o    = 4'b1111;
                illegal_o = |addr_lo_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahblite_bram_if.sv
// rtl/ahblite_bram_if.sv - AHB-Lite slave bridging to a 32-bit BRAM with registered read port
// Ports: AHB-Lite slave side (HCLK, HRESETn, HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE,
//        HWDATA, HREADY -> HREADYOUT, HRESP, HRDATA) and BRAM side (BRAM_RDADDR,
//        BRAM_WRADDR, BRAM_WDATA, BRAM_WRITE -> BRAM_RDATA one cycle after BRAM_RDADDR).
module ahblite_bram_if
    import ahblite_bram_if_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WRITE,
    input  logic [31:0]           BRAM_RDATA
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [3:0]            strb_q, strb_d;

    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            strb;
    logic                  illegal;
    logic                  accept;
    logic                  hazard;

    // Protection and the sequential/non-sequential distinction carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    assign idx = HADDR[ADDR_WIDTH+1:2];

    ahblite_bram_strb u_strb (
        .addr_lo_i (HADDR[1:0]),
        .size_i    (HSIZE),
        .strb_o    (strb),
        .illegal_o (illegal)
    );

    // HAZARD and ERR1 stretch the current data phase, so nothing new may start there.
    assign accept = HSEL & HTRANS[1] & HREADY
                  & (state_q != ST_HAZARD) & (state_q != ST_ERR1);

    // The BRAM write lands at the end of the WDATA cycle, so a same-word read issued
    // in that cycle would be handed the old contents.
    assign hazard = accept & ~HWRITE & ~illegal
                  & (state_q == ST_WDATA) & (idx == waddr_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            raddr_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        strb_d  = strb_q;
        case (state_q)
            ST_HAZARD: state_d = ST_RDATA;
            ST_ERR1:   state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (HWRITE) begin
                        state_d = ST_WDATA;
                        waddr_d = idx;
                        strb_d  = strb;
                    end else begin
                        state_d = hazard ? ST_HAZARD : ST_RDATA;
                        raddr_d = idx;
                    end
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT   = (state_q != ST_HAZARD) && (state_q != ST_ERR1);
        HRESP       = (state_q == ST_ERR1) || (state_q == ST_ERR2);
        HRDATA      = BRAM_RDATA;
        // During the stall the address phase on the bus already belongs to the next
        // transfer, so the read must be re-issued from the saved index.
        BRAM_RDADDR = (state_q == ST_HAZARD) ? raddr_q : idx;
        BRAM_WRADDR = waddr_q;
        BRAM_WDATA  = HWDATA;
        BRAM_WRITE  = ((state_q == ST_WDATA) && HRESETn) ? strb_q : 4'b0000;
    end

endmodule

// File: tb/tb_ahblite_bram_if.sv
// tb/tb_ahblite_bram_if.sv - self-checking bench for ahblite_bram_if
module tb_ahblite_bram_if;
    import ahblite_bram_if_pkg::*;

    localparam int AW     = 14;
    localparam int K_IDLE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = 32'h0;
    logic [1:0]    HTRANS = 2'b00;
    logic [2:0]    HSIZE = 3'd0;
    logic [3:0]    HPROT = 4'h3;
    logic          HWRITE = 1'b0;
    logic [31:0]   HWDATA = 32'h0;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] BRAM_RDADDR;
    logic [AW-1:0] BRAM_WRADDR;
    logic [31:0]   BRAM_WDATA;
    logic [3:0]    BRAM_WRITE;
    logic [31:0]   BRAM_RDATA = 32'h0;

    assign HREADY = HREADYOUT;

    ahblite_bram_if #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .BRAM_RDADDR(BRAM_RDADDR), .BRAM_WRADDR(BRAM_WRADDR), .BRAM_WDATA(BRAM_WDATA),
        .BRAM_WRITE(BRAM_WRITE), .BRAM_RDATA(BRAM_RDATA)
    );

    always #5 HCLK = ~HCLK;

    // BRAM: byte-enabled write, registered read returning pre-write contents.
    logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};
    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++)
            if (BRAM_WRITE[b]) mem[BRAM_WRADDR][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
        BRAM_RDATA <= mem[BRAM_RDADDR];
    end

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        xfer_t       x;
        logic [31:0] rdata;
        int          waits;
        logic        resp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    xfer_t       seq_q[$];
    vec_t        tbl[$];
    int          res_waits[$];
    logic [31:0] res_rdata[$];
    logic        res_resp_or[$];
    logic        res_resp_and[$];

    // Reference model: word array plus "was the previous transfer a write to this word".
    logic [31:0] model_mem [0:(1<<AW)-1] = '{default: 32'h0};
    logic        prev_wr  = 1'b0;
    int          prev_idx = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input xfer_t x, output logic [31:0] er, output int ew,
                              output logic eresp, output logic chk);
        int   idx, nbytes, first;
        logic legal;
        idx    = int'(x.addr[AW+1:2]);
        legal  = !(x.size >= 3 || (x.size == 1 && x.addr[0]) || (x.size == 2 && x.addr[1:0] != 0));
        er = 32'h0; ew = 0; eresp = 1'b0; chk = 1'b0;
        if (x.kind == K_IDLE) begin
            prev_wr = 1'b0;
        end else if (!legal) begin
            ew = 1; eresp = 1'b1;
            prev_wr = 1'b0;
        end else if (x.kind == K_WR) begin
            nbytes = 1 << x.size;
            first  = int'(x.addr[1:0]);
            for (int l = 0; l < 4; l++)
                if (l >= first && l < first + nbytes)
                    model_mem[idx][8*l +: 8] = x.wdata[8*l +: 8];
            prev_wr = 1'b1; prev_idx = idx;
        end else begin
            chk = 1'b1;
            er  = model_mem[idx];
            ew  = (prev_wr && prev_idx == idx) ? 1 : 0;
            prev_wr = 1'b0;
        end
    endtask

    // Pipelined master: drives seq_q back to back, records per-transfer data-phase results.
    task automatic run_seq();
        int a, d, n, cyc;
        logic rdy, rsp;
        logic [31:0] rd;
        n = seq_q.size(); a = 0; d = -1; cyc = 0;
        res_waits.delete(); res_rdata.delete(); res_resp_or.delete(); res_resp_and.delete();
        for (int i = 0; i < n; i++) begin
            res_waits.push_back(0); res_rdata.push_back(32'h0);
            res_resp_or.push_back(1'b0); res_resp_and.push_back(1'b1);
        end
        prev_wr = 1'b0;
        while ((a < n || d >= 0) && cyc < 2000) begin
            if (a < n) begin
                HSEL   = 1'b1;
                HTRANS = (seq_q[a].kind == K_IDLE) ? HTRANS_IDLE : HTRANS_NONSEQ;
                HWRITE = (seq_q[a].kind == K_WR);
                HADDR  = seq_q[a].addr;
                HSIZE  = seq_q[a].size;
            end else begin
                HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
            end
            HWDATA = (d >= 0) ? seq_q[d].wdata : 32'h0;
            @(negedge HCLK);
            rdy = HREADYOUT; rsp = HRESP; rd = HRDATA;
            if (d >= 0) begin
                if (!rdy) res_waits[d]++;
                res_resp_or[d]  = res_resp_or[d] | rsp;
                res_resp_and[d] = res_resp_and[d] & rsp;
                if (rdy) res_rdata[d] = rd;
            end
            @(posedge HCLK); #1;
            if (rdy) begin
                if (a < n) begin d = a; a++; end
                else d = -1;
            end
            cyc++;
        end
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'h0;
        n_tests++;
        if (cyc >= 2000) begin
            n_fail++;
            $display("FAIL run_seq timeout: %0d cycles used, limit %0d", cyc, 2000);
        end
    endtask

    task automatic add(input int k, input logic [31:0] ad, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [31:0] erd, input int ew, input logic ersp);
        vec_t v;
        v.x.kind = k; v.x.addr = ad; v.x.size = sz; v.x.wdata = wd;
        v.rdata = erd; v.waits = ew; v.resp = ersp;
        tbl.push_back(v);
    endtask

    task automatic check_vs_model(input string tag);
        logic [31:0] er; int ew; logic eresp, chk;
        for (int i = 0; i < seq_q.size(); i++) begin
            model_step(seq_q[i], er, ew, eresp, chk);
            check32($sformatf("%s[%0d] waits", tag, i), res_waits[i], ew);
            check32($sformatf("%s[%0d] resp", tag, i), {res_resp_or[i], res_resp_and[i]}, {2{eresp}});
            if (chk) check32($sformatf("%s[%0d] rdata", tag, i), res_rdata[i], er);
        end
    endtask

    task automatic gen_random(input int n);
        xfer_t x; int r;
        seq_q.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            x.kind  = (r == 0) ? K_IDLE : (r < 5) ? K_WR : K_RD;
            x.size  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            x.addr  = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) x.addr[31:16] = 16'($urandom);
            if ($urandom_range(0, 7) != 0) begin
                if (x.size == 3'd1) x.addr[0] = 1'b0;
                else if (x.size == 3'd2) x.addr[1:0] = 2'b00;
            end
            x.wdata = $urandom;
            seq_q.push_back(x);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er; int ew; logic eresp, chk;
        xfer_t x;

        // Directed vectors: {kind, addr, size, wdata} -> {rdata, wait states, HRESP}
        add(K_WR,   32'h0000_0013, 3'd0, 32'hABCDEF01, 32'h0,        0, 1'b0);
        add(K_IDLE, 32'h0,         3'd0, 32'h0,        32'h0,        0, 1'b0);
        add(K_RD,   32'h0000_0010, 3'd2, 32'h0,        32'hAB000000, 0, 1'b0);
        add(K_WR,   32'h0000_0010, 3'd2, 32'h11223344, 32'h0,        0, 1'b0);
        add(K_RD,   32'h0000_0010, 3'd2, 32'h0,        32'h11223344, 1, 1'b0);
        add(K_WR,   32'h0000_0020, 3'd2, 32'h55667788, 32'h0,        0, 1'b0);
        add(K_WR,   32'h0000_0021, 3'd1, 32'hFFFFFFFF, 32'h0,        1, 1'b1);
        add(K_RD,   32'h0000_0020, 3'd2, 32'h0,        32'h55667788, 0, 1'b0);
        add(K_RD,   32'h0000_0023, 3'd3, 32'h0,        32'h0,        1, 1'b1);
        add(K_WR,   32'h0000_0022, 3'd1, 32'h1234ABCD, 32'h0,        0, 1'b0);
        add(K_RD,   32'h0000_0020, 3'd2, 32'h0,        32'h12347788, 1, 1'b0);
        add(K_WR,   32'h0000_0000, 3'd2, 32'h01010101, 32'h0,        0, 1'b0);
        add(K_WR,   32'h0000_0004, 3'd2, 32'h02020202, 32'h0,        0, 1'b0);
        add(K_WR,   32'h0000_0008, 3'd2, 32'h03030303, 32'h0,        0, 1'b0);
        add(K_RD,   32'h0000_0008, 3'd2, 32'h0,        32'h03030303, 1, 1'b0);
        add(K_RD,   32'h0000_0000, 3'd2, 32'h0,        32'h01010101, 0, 1'b0);
        add(K_RD,   32'h0000_0004, 3'd2, 32'h0,        32'h02020202, 0, 1'b0);
        add(K_WR,   32'h0000_0004, 3'd2, 32'h0A0B0C0D, 32'h0,        0, 1'b0);
        add(K_RD,   32'h0000_0004, 3'd2, 32'h0,        32'h0A0B0C0D, 1, 1'b0);
        add(K_WR,   32'h0001_0000, 3'd2, 32'hCAFEF00D, 32'h0,        0, 1'b0);
        add(K_IDLE, 32'h0,         3'd0, 32'h0,        32'h0,        0, 1'b0);
        add(K_RD,   32'h0000_0000, 3'd2, 32'h0,        32'hCAFEF00D, 0, 1'b0);
        add(K_WR,   32'h0000_0002, 3'd0, 32'h00EE0000, 32'h0,        0, 1'b0);
        add(K_RD,   32'h0000_0001, 3'd0, 32'h0,        32'hCAEEF00D, 1, 1'b0);

        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        check32("reset HREADYOUT", HREADYOUT, 1'b1);
        check32("reset HRESP", HRESP, 1'b0);
        check32("reset BRAM_WRITE", BRAM_WRITE, 4'h0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Table-driven directed sequence
        seq_q.delete();
        foreach (tbl[i]) seq_q.push_back(tbl[i].x);
        run_seq();
        foreach (tbl[i]) begin
            model_step(tbl[i].x, er, ew, eresp, chk);
            check32($sformatf("vec[%0d] waits", i), res_waits[i], tbl[i].waits);
            check32($sformatf("vec[%0d] resp", i), {res_resp_or[i], res_resp_and[i]}, {2{tbl[i].resp}});
            if (tbl[i].x.kind == K_RD && !tbl[i].resp)
                check32($sformatf("vec[%0d] rdata", i), res_rdata[i], tbl[i].rdata);
        end

        // Reset during a write data phase suppresses the write
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'hDEADBEEF;
        check32("rstw write active", BRAM_WRITE, 4'hF);
        HRESETn = 1'b0; #1;
        check32("rstw BRAM_WRITE", BRAM_WRITE, 4'h0);
        check32("rstw HREADYOUT", HREADYOUT, 1'b1);
        check32("rstw HRESP", HRESP, 1'b0);
        @(posedge HCLK); #1;
        check32("rstw BRAM_WRITE held", BRAM_WRITE, 4'h0);
        HRESETn = 1'b1; HWDATA = 32'h0;
        @(posedge HCLK); #1;
        seq_q.delete();
        x.kind = K_RD; x.addr = 32'h40; x.size = 3'd2; x.wdata = 32'h0;
        seq_q.push_back(x);
        run_seq();
        check_vs_model("rstw_rd");

        // Reset during the hazard stall abandons the read
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h50; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HWRITE = 1'b0; HWDATA = 32'h00000077;
        @(posedge HCLK); #1;
        x.kind = K_WR; x.addr = 32'h50; x.size = 3'd2; x.wdata = 32'h00000077;
        model_step(x, er, ew, eresp, chk);
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'h0;
        check32("rsth stalled", HREADYOUT, 1'b0);
        HRESETn = 1'b0; #1;
        check32("rsth HREADYOUT", HREADYOUT, 1'b1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        seq_q.delete();
        x.kind = K_RD; x.addr = 32'h50; x.size = 3'd2; x.wdata = 32'h0;
        seq_q.push_back(x);
        run_seq();
        check_vs_model("rsth_rd");

        // Randomized traffic against the reference model
        for (int b = 0; b < 5; b++) begin
            gen_random(40);
            run_seq();
            check_vs_model($sformatf("rand%0d", b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
